mf_cken_synth: RTL



---
 rtl/mf_cken_synth.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/mf_cken_synth.sv
// mf_cken_synth: NUM_CH-channel NCO clock-enable synthesizer with a
// PLL-style lock indicator that settles after every reconfiguration.
//
// Ports:
//   refclk     sole clock, rising edge
//   rst        synchronous active-high reset
//   cfg_valid  config write request
//   cfg_ready  config write can be accepted (low in APPLY and in reset)
//   cfg_ch     target channel; values >= NUM_CH are consumed, ignored
//   cfg_inc    phase increment, f_out = f_refclk * inc / 2^ACC_W
//   cfg_phase  accumulator reload value (phase offset)
//   ch_en      per-channel run enable
//   cken       one-cycle strobe per accumulator carry (registered)
//   clk_level  accumulator MSB, square wave (registered)
//   locked     outputs settled
//
// Optional feature macro: MF_CKEN_PHASE_ALIGN_EN
//   defined   -> every channel reloads its phase when a write is applied
//   undefined -> only the written channel reloads
module mf_cken_synth #(
    parameter int NUM_CH      = 5,
    parameter int ACC_W       = 32,
    parameter int LOCK_CYCLES = 1024,
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [ACC_W-1:0]  cfg_inc,
    input  logic [ACC_W-1:0]  cfg_phase,
    input  logic [NUM_CH-1:0] ch_en,
    output logic [NUM_CH-1:0] cken,
    output logic [NUM_CH-1:0] clk_level,
    output logic              locked
);

    localparam int CNT_W = $clog2(LOCK_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

    typedef enum logic [1:0] {
        SETTLE,
        LOCKED,
        APPLY
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  lock_cnt_q, lock_cnt_d;
    logic              locked_q, locked_d;
`ifndef MF_CKEN_PHASE_ALIGN_EN
    logic [CH_W-1:0]   apply_ch_q, apply_ch_d;
`endif

    logic [ACC_W-1:0]  inc_q [NUM_CH];
    logic [ACC_W-1:0]  inc_d [NUM_CH];
    logic [ACC_W-1:0]  ph_q  [NUM_CH];
    logic [ACC_W-1:0]  ph_d  [NUM_CH];
    logic [ACC_W-1:0]  acc_q [NUM_CH];
    logic [ACC_W-1:0]  acc_d [NUM_CH];
    logic [ACC_W:0]    sum   [NUM_CH];
    logic [NUM_CH-1:0] cken_q, cken_d;
    logic [NUM_CH-1:0] lvl_q, lvl_d;

    logic accept;
    logic ch_ok;
    logic wr;
    logic reload;
    logic hit;

    assign cfg_ready = !rst && (state_q != APPLY);
    assign accept    = cfg_valid && cfg_ready;
    assign ch_ok     = (int'(cfg_ch) < NUM_CH);
    assign reload    = (state_q == APPLY);

    assign cken      = cken_q;
    assign clk_level = lvl_q;
    assign locked    = locked_q;

    // Control FSM: an accepted write parks in APPLY for one cycle, then
    // the lock counter restarts from zero in SETTLE.
    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        locked_d   = locked_q;
        wr         = 1'b0;
`ifndef MF_CKEN_PHASE_ALIGN_EN
        apply_ch_d = apply_ch_q;
`endif
        unique case (state_q)
            SETTLE: begin
                if (accept && ch_ok) begin
                    wr       = 1'b1;
                    locked_d = 1'b0;
                    state_d  = APPLY;
                end else if (lock_cnt_q == CNT_LAST) begin
                    locked_d = 1'b1;
                    state_d  = LOCKED;
                end else begin
                    lock_cnt_d = lock_cnt_q + CNT_W'(1);
                end
            end
            LOCKED: begin
                if (accept && ch_ok) begin
                    wr       = 1'b1;
                    locked_d = 1'b0;
                    state_d  = APPLY;
                end
            end
            APPLY: begin
                lock_cnt_d = '0;
                state_d    = SETTLE;
            end
            default: begin
                state_d = SETTLE;
            end
        endcase
`ifndef MF_CKEN_PHASE_ALIGN_EN
        if (wr) begin
            apply_ch_d = cfg_ch;
        end
`endif
    end

    // Per-channel NCO. A disabled channel freezes its accumulator and
    // forces both outputs low; a reload overrides whatever the add did.
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            inc_d[i] = inc_q[i];
            ph_d[i]  = ph_q[i];
            if (wr && (int'(cfg_ch) == i)) begin
                inc_d[i] = cfg_inc;
                ph_d[i]  = cfg_phase;
            end

            sum[i] = {1'b0, acc_q[i]} + {1'b0, inc_q[i]};
            if (ch_en[i]) begin
                acc_d[i]  = sum[i][ACC_W-1:0];
                cken_d[i] = sum[i][ACC_W];
                lvl_d[i]  = sum[i][ACC_W-1];
            end else begin
                acc_d[i]  = acc_q[i];
                cken_d[i] = 1'b0;
                lvl_d[i]  = 1'b0;
            end

`ifdef MF_CKEN_PHASE_ALIGN_EN
            hit = reload;
`else
            hit = reload && (int'(apply_ch_q) == i);
`endif
            if (hit) begin
                acc_d[i]  = ph_q[i];
                cken_d[i] = 1'b0;
                lvl_d[i]  = ch_en[i] & ph_q[i][ACC_W-1];
            end
        end
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q    <= SETTLE;
            lock_cnt_q <= '0;
            locked_q   <= 1'b0;
`ifndef MF_CKEN_PHASE_ALIGN_EN
            apply_ch_q <= '0;
`endif
            cken_q     <= '0;
            lvl_q      <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                inc_q[i] <= '0;
                ph_q[i]  <= '0;
                acc_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
            locked_q   <= locked_d;
`ifndef MF_CKEN_PHASE_ALIGN_EN
            apply_ch_q <= apply_ch_d;
`endif
            cken_q     <= cken_d;
            lvl_q      <= lvl_d;
            for (int i = 0; i < NUM_CH; i++) begin
                inc_q[i] <= inc_d[i];
                ph_q[i]  <= ph_d[i];
                acc_q[i] <= acc_d[i];
            end
        end
    end

endmodule
